// File: rtl/ttl_inverter_bank.sv
// Bank of independent TTL-style gate channels: per-channel glitch filter,
// polarity mask and whole-clock propagation delay.
module ttl_inverter_bank #(
    parameter int unsigned CHANNELS    = 6,
    parameter              INVERT_MASK = {CHANNELS{1'b1}},
    parameter int unsigned FILTER      = 0,
    parameter int unsigned DELAY       = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic [CHANNELS-1:0] a,
    output logic [CHANNELS-1:0] y,
    output logic [CHANNELS-1:0] changed
);

    localparam int unsigned FMAX = (FILTER == 0) ? 1 : FILTER;
    localparam int unsigned CW   = $clog2(FMAX + 1);

    localparam logic [CHANNELS-1:0] MASK     = CHANNELS'(INVERT_MASK);
    localparam logic [CW-1:0]       CNT_LAST = CW'(FMAX - 1);

    // Elaboration-time parameter range guards
    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
        $error("ttl_inverter_bank: CHANNELS must be 1..32");
    end
    if (FILTER > 255) begin : g_bad_filter
        $error("ttl_inverter_bank: FILTER must be 0..255");
    end
    if (DELAY > 16) begin : g_bad_delay
        $error("ttl_inverter_bank: DELAY must be 0..16");
    end
    if ($bits(INVERT_MASK) != CHANNELS) begin : g_bad_mask
        $error("ttl_inverter_bank: INVERT_MASK width must equal CHANNELS");
    end

    logic [CHANNELS-1:0]         f_q;
    logic [CHANNELS-1:0]         f_d;
    logic [CHANNELS-1:0][CW-1:0] cnt_q;
    logic [CHANNELS-1:0][CW-1:0] cnt_d;
    logic [CHANNELS-1:0]         y_prev_q;
    logic [CHANNELS-1:0]         y_prev_d;
    logic [CHANNELS-1:0]         pipe_in;

    // Glitch filter: accept a new level only after FMAX consecutive differing samples
    always_comb begin
        f_d   = f_q;
        cnt_d = cnt_q;
        if (ce) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (a[i] == f_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    f_d[i]   = a[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q   <= '0;
            cnt_q <= '0;
        end else begin
            f_q   <= f_d;
            cnt_q <= cnt_d;
        end
    end

    assign pipe_in = f_q ^ MASK;

    if (DELAY == 0) begin : g_no_delay
        assign y = pipe_in;
    end else begin : g_delay
        logic [DELAY-1:0][CHANNELS-1:0] pipe_q;
        logic [DELAY-1:0][CHANNELS-1:0] pipe_d;

        // Propagation delay line, shifts only on enabled clocks
        always_comb begin
            pipe_d = pipe_q;
            if (ce) begin
                pipe_d[0] = pipe_in;
                for (int s = 1; s < int'(DELAY); s++) begin
                    pipe_d[s] = pipe_q[s-1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_q <= {DELAY{MASK}};
            end else begin
                pipe_q <= pipe_d;
            end
        end

        assign y = pipe_q[DELAY-1];
    end

    // Edge tracker runs every clock so a toggle is flagged for exactly one cycle
    always_comb begin
        y_prev_d = y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_prev_q <= MASK;
        end else begin
            y_prev_q <= y_prev_d;
        end
    end

    assign changed = y ^ y_prev_q;

endmodule

// File: tb/tb_ttl_inverter_bank.sv
// Self-checking bench for ttl_inverter_bank across several parameter sets.
module tb_ttl_inverter_bank;

    typedef struct {
        int          dut;
        logic [11:0] a;
        logic        ce;
        logic [11:0] y;
        logic [11:0] chg;
    } vec_t;

    typedef struct {
        int          dut;
        int          idx;
        logic [11:0] y;
        logic [11:0] chg;
    } exp_t;

    logic clk;
    logic rst_n;

    logic [5:0]  a0, a1, a2, a3;
    logic [11:0] a4;
    logic        ce0, ce1, ce2, ce3, ce4;
    logic [5:0]  y0, y1, y2, y3;
    logic [11:0] y4;
    logic [5:0]  ch0, ch1, ch2, ch3;
    logic [11:0] ch4;

    int n_checks;
    int n_pass;

    vec_t tbl[$];
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ttl_inverter_bank u0 (
        .clk(clk), .rst_n(rst_n), .ce(ce0), .a(a0), .y(y0), .changed(ch0)
    );

    ttl_inverter_bank #(.CHANNELS(6), .INVERT_MASK(6'b101010)) u1 (
        .clk(clk), .rst_n(rst_n), .ce(ce1), .a(a1), .y(y1), .changed(ch1)
    );

    ttl_inverter_bank #(.CHANNELS(6), .FILTER(3), .DELAY(0)) u2 (
        .clk(clk), .rst_n(rst_n), .ce(ce2), .a(a2), .y(y2), .changed(ch2)
    );

    ttl_inverter_bank #(.CHANNELS(6), .DELAY(4)) u3 (
        .clk(clk), .rst_n(rst_n), .ce(ce3), .a(a3), .y(y3), .changed(ch3)
    );

    ttl_inverter_bank #(.CHANNELS(12), .FILTER(2), .DELAY(3)) u4 (
        .clk(clk), .rst_n(rst_n), .ce(ce4), .a(a4), .y(y4), .changed(ch4)
    );

    function automatic logic [11:0] dut_y(int d);
        case (d)
            0:       return 12'(y0);
            1:       return 12'(y1);
            2:       return 12'(y2);
            3:       return 12'(y3);
            default: return y4;
        endcase
    endfunction

    function automatic logic [11:0] dut_chg(int d);
        case (d)
            0:       return 12'(ch0);
            1:       return 12'(ch1);
            2:       return 12'(ch2);
            3:       return 12'(ch3);
            default: return ch4;
        endcase
    endfunction

    task automatic drive(int d, logic [11:0] av, logic cev);
        case (d)
            0:       begin a0 = av[5:0]; ce0 = cev; end
            1:       begin a1 = av[5:0]; ce1 = cev; end
            2:       begin a2 = av[5:0]; ce2 = cev; end
            3:       begin a3 = av[5:0]; ce3 = cev; end
            default: begin a4 = av;      ce4 = cev; end
        endcase
    endtask

    task automatic check(string name, logic [11:0] got, logic [11:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %03h required %03h", name, got, exp);
    endtask

    function automatic void add(int d, logic [11:0] av, logic cev,
                                logic [11:0] yv, logic [11:0] cv);
        vec_t v;
        v.dut = d; v.a = av; v.ce = cev; v.y = yv; v.chg = cv;
        tbl.push_back(v);
    endfunction

    // Drive one vector, queue its expectation, compare once the edge has passed
    task automatic apply(vec_t v, int idx);
        exp_t e;
        drive(v.dut, v.a, v.ce);
        e.dut = v.dut; e.idx = idx; e.y = v.y; e.chg = v.chg;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("u%0d_v%0d_y", e.dut, e.idx), dut_y(e.dut), e.y);
        check($sformatf("u%0d_v%0d_changed", e.dut, e.idx), dut_chg(e.dut), e.chg);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0; a4 = '0;
        ce0 = 1'b1; ce1 = 1'b1; ce2 = 1'b1; ce3 = 1'b1; ce4 = 1'b1;

        // Defaults: inversion, two-edge latency, one-cycle changed, ce hold
        add(0, 12'h000, 1'b1, 12'h03F, 12'h000);
        add(0, 12'h03F, 1'b1, 12'h03F, 12'h000);
        add(0, 12'h03F, 1'b1, 12'h000, 12'h03F);
        add(0, 12'h03F, 1'b1, 12'h000, 12'h000);
        add(0, 12'h000, 1'b1, 12'h000, 12'h000);
        add(0, 12'h000, 1'b1, 12'h03F, 12'h03F);
        add(0, 12'h000, 1'b1, 12'h03F, 12'h000);
        add(0, 12'h001, 1'b1, 12'h03F, 12'h000);
        for (int k = 0; k < 5; k++) add(0, 12'h001, 1'b0, 12'h03F, 12'h000);
        add(0, 12'h001, 1'b1, 12'h03E, 12'h001);
        add(0, 12'h001, 1'b1, 12'h03E, 12'h000);
        // Mixed polarity mask
        add(1, 12'h03F, 1'b1, 12'h02A, 12'h000);
        add(1, 12'h03F, 1'b1, 12'h015, 12'h03F);
        add(1, 12'h03F, 1'b1, 12'h015, 12'h000);
        add(1, 12'h000, 1'b1, 12'h015, 12'h000);
        add(1, 12'h000, 1'b1, 12'h02A, 12'h03F);
        add(1, 12'h000, 1'b1, 12'h02A, 12'h000);
        // FILTER=3, DELAY=0: short pulse rejected, held level accepted, toggling ignored
        add(2, 12'h001, 1'b1, 12'h03F, 12'h000);
        add(2, 12'h001, 1'b1, 12'h03F, 12'h000);
        add(2, 12'h000, 1'b1, 12'h03F, 12'h000);
        add(2, 12'h000, 1'b1, 12'h03F, 12'h000);
        add(2, 12'h001, 1'b1, 12'h03F, 12'h000);
        add(2, 12'h001, 1'b1, 12'h03F, 12'h000);
        add(2, 12'h001, 1'b1, 12'h03E, 12'h001);
        add(2, 12'h001, 1'b1, 12'h03E, 12'h000);
        for (int k = 0; k < 3; k++) begin
            add(2, 12'h000, 1'b1, 12'h03E, 12'h000);
            add(2, 12'h001, 1'b1, 12'h03E, 12'h000);
        end
        // 12 channels, FILTER=2, DELAY=3: staggered changes, latency 5 each
        add(4, 12'h001, 1'b1, 12'hFFF, 12'h000);
        add(4, 12'h021, 1'b1, 12'hFFF, 12'h000);
        add(4, 12'h821, 1'b1, 12'hFFF, 12'h000);
        add(4, 12'h821, 1'b1, 12'hFFF, 12'h000);
        add(4, 12'h821, 1'b1, 12'hFFE, 12'h001);
        add(4, 12'h821, 1'b1, 12'hFDE, 12'h020);
        add(4, 12'h821, 1'b1, 12'h7DE, 12'h800);
        add(4, 12'h821, 1'b1, 12'h7DE, 12'h000);

        #12;
        for (int d = 0; d < 5; d++) begin
            check($sformatf("reset_u%0d_changed", d), dut_chg(d), 12'h000);
        end
        check("reset_u0_y", dut_y(0), 12'h03F);
        check("reset_u1_y", dut_y(1), 12'h02A);
        check("reset_u2_y", dut_y(2), 12'h03F);
        check("reset_u3_y", dut_y(3), 12'h03F);
        check("reset_u4_y", dut_y(4), 12'hFFF);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // DELAY=4: push a change two stages deep, then reset asynchronously
        v.dut = 3; v.a = 12'h03F; v.ce = 1'b1; v.y = 12'h03F; v.chg = 12'h000;
        for (int k = 0; k < 3; k++) apply(v, 100 + k);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_u3_y", dut_y(3), 12'h03F);
        check("async_rst_u3_changed", dut_chg(3), 12'h000);
        check("async_rst_u4_y", dut_y(4), 12'hFFF);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) apply(v, 110 + k);
        v.y = 12'h000; v.chg = 12'h03F;
        apply(v, 114);
        v.chg = 12'h000;
        apply(v, 115);

        check("scoreboard_drained", 12'(sb.size()), 12'h000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ttl_inverter_bank.md
Name: ttl_inverter_bank

Overview:
- Parametrised, clocked successor to the discrete hex-inverter models.
- Provides CHANNELS independent gate channels. Each channel is inverting or non-inverting, set per channel by a mask.
- Each channel has a glitch filter and a configurable propagation delay in whole clocks, so board-level TTL timing can be emulated inside the synchronous video/logic domain.
- Sits between raw board-signal nets and downstream registered logic.

Parameters:
- CHANNELS, 6, number of independent channels (1..32).
- INVERT_MASK, {CHANNELS{1'b1}}, bit i = 1 inverts channel i; bit i = 0 passes it through.
- FILTER, 0, number of consecutive enabled clocks an input must differ from the filtered value before it is accepted (0..255). 0 behaves as 1.
- DELAY, 1, number of pipeline stages after the filter (0..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ce  input  1  clock enable; all filter/pipeline state advances only when high.
- a  input  CHANNELS  channel inputs, sampled on rising clk.
- y  output  CHANNELS  channel outputs, registered (DELAY>=1) or from filter register (DELAY=0).
- changed  output  CHANNELS  bit i high for the one cycle immediately after y[i] changed.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately): all filter registers f=0, all counters 0, all pipeline stages = INVERT_MASK, so y = INVERT_MASK. changed = 0. Internal y_prev = INVERT_MASK.
- Release of reset is synchronous to the next clk edge; no pending change survives reset.
- Filter, per channel i, on each rising clk with ce=1:
  - if a[i]==f[i]: cnt[i]<=0.
  - else if cnt[i]==max(FILTER,1)-1: f[i]<=a[i], cnt[i]<=0.
  - else: cnt[i]<=cnt[i]+1.
- Counter width is clog2(max(FILTER,1)+1). The counter never wraps.
- A pulse shorter than max(FILTER,1) enabled clocks is discarded and the counter is cleared.
- Polarity: the pipeline input is f ^ INVERT_MASK.
- Delay line:
  - DELAY stages, each shifting on ce=1.
  - DELAY=0: y = f ^ INVERT_MASK, which is still registered via f.
- Latency from a stable input change to y: max(FILTER,1)+DELAY enabled rising edges.
- ce=0: f, cnt and all stages hold; the pending count is neither reset nor advanced. Latency resumes where it stopped.
- changed: y_prev<=y on every rising clk, independent of ce. changed = y ^ y_prev. Each toggle of y therefore yields exactly one cycle of changed.
- Channels are fully independent; simultaneous changes on several channels propagate in parallel with identical latency.
- Input toggling every clock with FILTER>=2: y never changes.
- Parameter range violations (CHANNELS, FILTER, DELAY, or INVERT_MASK width mismatch) fail elaboration.

Test Plan:
- Defaults (6 ch, mask 6'h3F, FILTER=0, DELAY=1): after reset y=6'h3F, changed=0. Drive a=6'h00 then 6'h3F -> y=6'h00 two edges after a changes; changed=6'h3F for exactly one cycle.
- INVERT_MASK=6'b101010, a=6'h3F held -> y=6'h15 after 2 edges. Then a=6'h00 -> y=6'h2A.
- FILTER=3, DELAY=0, 6 ch, a[0] high for 2 clocks then low -> y unchanged, changed=0. a[0] held high -> y[0] toggles at the 3rd edge, with changed[0]=1 for one cycle.
- Defaults, a changes to 6'h01; ce=0 for 5 clocks after the first edge -> y holds. After ce returns high, y[0] toggles at the next enabled edge (total 2 enabled edges).
- DELAY=4, rst_n pulsed low asynchronously mid-cycle while a change is 2 stages deep -> y=INVERT_MASK immediately, changed=0. With a held at its value after reset, y reaches a^mask 5 edges after release.
- CHANNELS=12, FILTER=2, DELAY=3: staggered changes on channels 0, 5 and 11, one clock apart -> each y bit toggles exactly 5 edges after its own input, and the other bits stay unaffected.
